seq_stream_ctrl: RTL and testbench
==================================

// Module: seq_stream_ctrl
// PURPOSE
//  Sequencer for the mealy_overlap_10110 detector. Accepts parallel words over a valid/ready
//  handshake and shifts each word MSB-first into the detector's data_in, one bit per clock.
//  Counts the detector's data_out hits per word and returns count + first-hit position over a
//  valid/ready result port. Each word is detected independently: detector is reset between words.
// PARAMETERS
//  WORD_W  8  bits per input word (>=2); shifted MSB first
//  CNT_W   4  width of per-word hit counter (saturating)
//  (local) POS_W = $clog2(WORD_W)+1  width of first-hit position field
// PORTS
//  clk           in   1        system clock, all logic on rising edge
//  rst           in   1        synchronous, active-high reset
//  in_valid      in   1        input word valid
//  in_data       in   WORD_W   input word
//  in_ready      out  1        controller can accept a word (IDLE only)
//  det_rst       out  1        to detector rst; synchronous clear of detector FSM
//  det_data_in   out  1        to detector data_in; current serial bit
//  det_data_out  in   1        from detector data_out; Mealy hit for current bit
//  out_valid     out  1        result valid
//  out_count     out  CNT_W    hits in word, saturates at 2^CNT_W-1
//  out_first     out  POS_W    bit index (0 = MSB) of first hit; WORD_W if no hit
//  out_ready     in   1        result consumer ready
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=IDLE; in_ready=1, out_valid=0, out_count=0,
//   out_first=WORD_W, det_rst=1, det_data_in=0. Reset wins over every other event.
//  FSM states: IDLE, SHIFT, DONE.
//  IDLE: in_ready=1, det_rst=1, det_data_in=0. On in_valid&in_ready: load shift reg
//   <= in_data, idx<=0, cnt<=0, first<=WORD_W; -> SHIFT. Detector is held in reset
//   through the accept edge, so its first SHIFT bit starts from the reset state.
//  SHIFT: in_ready=0, det_rst=0, det_data_in=sr[WORD_W-1]. Each edge: if det_data_out,
//   cnt<=sat(cnt+1) and, if first==WORD_W, first<=idx; sr<=sr<<1; idx<=idx+1.
//   det_data_out is Mealy (combinational on current bit): sample it the same cycle.
//   On edge with idx==WORD_W-1 -> DONE (last bit's hit is counted on that edge).
//  DONE: out_valid=1, out_count=cnt, out_first=first, det_rst=1, det_data_in=0.
//   Outputs stable while out_ready=0. On out_valid&out_ready -> IDLE.
//  Latency: out_valid rises exactly WORD_W clocks after accept edge; in_ready rises
//   the clock after the result handshake. Throughput: one word per WORD_W+2 clocks.
//  Saturation: cnt stops at 2^CNT_W-1; first still records correctly.
//  in_valid while in_ready=0 is ignored (producer must hold data); in_data sampled
//   only on the accept edge.
//  Overlap across words: none; every word restarts detector from reset.
//  Reset mid-SHIFT or mid-DONE: word/result discarded, no out_valid pulse, IDLE next cycle.
// TESTING
//  T1 WORD_W=8: in_data=8'b10110110 -> hits at idx 4,7; out_count=2, out_first=4,
//     out_valid exactly 8 clocks after accept.
//  T2 in_data=8'h00 then 8'hFF -> both out_count=0, out_first=8; det_data_out never 1.
//  T3 back-to-back words 8'b00000101, 8'b10000000 -> each count=0 (no cross-word
//     overlap: det_rst high between words); in_ready only in IDLE.
//  T4 WORD_W=32, CNT_W=2: in_data=32'hB6DB6DB6 (10 hits) -> out_count=3 (saturated),
//     out_first=4.
//  T5 out_ready=0 for 5 clocks in DONE -> out_valid/out_count/out_first stable,
//     in_ready=0; in_valid pulses during that time not accepted.
//  T6 rst=1 at third SHIFT clock of 8'b10110110 -> next cycle in_ready=1,
//     out_valid=0, det_rst=1; re-sent word gives count=2, first=4.

Source files
------------

// File: rtl/seq_stream_ctrl.sv
// Word-to-serial sequencer for the mealy_overlap_10110 detector.
// Shifts each accepted word MSB-first and reports hit count and first-hit index.
module seq_stream_ctrl #(
    parameter  int WORD_W = 8,
    parameter  int CNT_W  = 4,
    localparam int POS_W  = $clog2(WORD_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [WORD_W-1:0] in_data,
    output logic              in_ready,
    output logic              det_rst,
    output logic              det_data_in,
    input  logic              det_data_out,
    output logic              out_valid,
    output logic [CNT_W-1:0]  out_count,
    output logic [POS_W-1:0]  out_first,
    input  logic              out_ready
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [POS_W-1:0] NO_HIT  = POS_W'(WORD_W);
    localparam logic [POS_W-1:0] LAST    = POS_W'(WORD_W - 1);

    state_t              state_q;
    logic [WORD_W-1:0]   sr_q;
    logic [POS_W-1:0]    idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [CNT_W-1:0]    cnt_d;
    logic [POS_W-1:0]    first_q;
    logic [POS_W-1:0]    first_d;
    logic                in_ready_q;
    logic                det_rst_q;
    logic                out_valid_q;
    logic [CNT_W-1:0]    out_count_q;
    logic [POS_W-1:0]    out_first_q;

    // Detector output is Mealy: fold the current bit's hit in before the edge.
    always_comb begin
        cnt_d   = cnt_q;
        first_d = first_q;
        if (det_data_out) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (first_q == NO_HIT) begin
                first_d = idx_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sr_q        <= '0;
            idx_q       <= '0;
            cnt_q       <= '0;
            first_q     <= NO_HIT;
            in_ready_q  <= 1'b1;
            det_rst_q   <= 1'b1;
            out_valid_q <= 1'b0;
            out_count_q <= '0;
            out_first_q <= NO_HIT;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        sr_q       <= in_data;
                        idx_q      <= '0;
                        cnt_q      <= '0;
                        first_q    <= NO_HIT;
                        in_ready_q <= 1'b0;
                        det_rst_q  <= 1'b0;
                        state_q    <= SHIFT;
                    end
                end
                SHIFT: begin
                    cnt_q   <= cnt_d;
                    first_q <= first_d;
                    sr_q    <= sr_q << 1;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST) begin
                        state_q     <= DONE;
                        det_rst_q   <= 1'b1;
                        out_valid_q <= 1'b1;
                        out_count_q <= cnt_d;
                        out_first_q <= first_d;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // After WORD_W shifts the register is all zero, so its MSB is 0 outside SHIFT.
    assign det_data_in = sr_q[WORD_W-1];
    assign in_ready    = in_ready_q;
    assign det_rst     = det_rst_q;
    assign out_valid   = out_valid_q;
    assign out_count   = out_count_q;
    assign out_first   = out_first_q;

endmodule

// File: tb/tb_seq_stream_ctrl.sv
// Self-checking bench for seq_stream_ctrl with a behavioural 10110 Mealy detector.
// Covers the default 8-bit instance and a 32-bit instance with a 2-bit counter.
module tb_seq_stream_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       in_valid = 1'b0;
    logic [7:0] in_data  = '0;
    logic       in_ready;
    logic       det_rst;
    logic       det_data_in;
    logic       det_data_out;
    logic       out_valid;
    logic [3:0] out_count;
    logic [3:0] out_first;
    logic       out_ready = 1'b1;

    logic        in_valid2 = 1'b0;
    logic [31:0] in_data2  = '0;
    logic        in_ready2;
    logic        det_rst2;
    logic        det_data_in2;
    logic        det_data_out2;
    logic        out_valid2;
    logic [1:0]  out_count2;
    logic [5:0]  out_first2;
    logic        out_ready2 = 1'b1;

    seq_stream_ctrl dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .det_rst(det_rst), .det_data_in(det_data_in),
        .det_data_out(det_data_out),
        .out_valid(out_valid), .out_count(out_count),
        .out_first(out_first), .out_ready(out_ready)
    );

    seq_stream_ctrl #(.WORD_W(32), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid2), .in_data(in_data2), .in_ready(in_ready2),
        .det_rst(det_rst2), .det_data_in(det_data_in2),
        .det_data_out(det_data_out2),
        .out_valid(out_valid2), .out_count(out_count2),
        .out_first(out_first2), .out_ready(out_ready2)
    );

    // States: 0 none, 1 "1", 2 "10", 3 "101", 4 "1011".
    function automatic logic [2:0] dnext(input logic [2:0] s, input logic b);
        case (s)
            3'd0:    return b ? 3'd1 : 3'd0;
            3'd1:    return b ? 3'd1 : 3'd2;
            3'd2:    return b ? 3'd3 : 3'd0;
            3'd3:    return b ? 3'd4 : 3'd2;
            3'd4:    return b ? 3'd1 : 3'd2;
            default: return 3'd0;
        endcase
    endfunction

    logic [2:0] d1_q = '0;
    logic [2:0] d2_q = '0;
    always @(posedge clk) d1_q <= det_rst  ? 3'd0 : dnext(d1_q, det_data_in);
    always @(posedge clk) d2_q <= det_rst2 ? 3'd0 : dnext(d2_q, det_data_in2);
    assign det_data_out  = (d1_q == 3'd4) && !det_data_in;
    assign det_data_out2 = (d2_q == 3'd4) && !det_data_in2;

    int viol = 0;
    always @(negedge clk) begin
        if (!rst && in_ready && (out_valid || !det_rst)) viol <= viol + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic send_word(input logic [7:0] d, output int lat,
                             output int c, output int f);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("accept_timeout", int'(n < 50), 1);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("result_timeout", int'(lat < 40), 1);
        c = int'(out_count);
        f = int'(out_first);
    endtask

    typedef struct {
        logic [7:0] data;
        int         cnt;
        int         first;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat, c, f, n, t0, t1, seen;

        vecs[0] = '{8'b10110110, 2, 4};
        vecs[1] = '{8'h00,       0, 8};
        vecs[2] = '{8'hFF,       0, 8};
        vecs[3] = '{8'b10110000, 1, 4};
        vecs[4] = '{8'b01011010, 1, 5};
        vecs[5] = '{8'b10110101, 1, 4};
        vecs[6] = '{8'b11011011, 1, 5};
        vecs[7] = '{8'b00000101, 0, 8};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_first", int'(out_first), 8);
        chk("rst_det_rst",   int'(det_rst), 1);
        chk("rst_det_in",    int'(det_data_in), 0);
        chk("rst_first2",    int'(out_first2), 32);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            send_word(vecs[i].data, lat, c, f);
            chk($sformatf("v%0d_latency", i), lat, 8);
            chk($sformatf("v%0d_count", i), c, vecs[i].cnt);
            chk($sformatf("v%0d_first", i), f, vecs[i].first);
            @(negedge clk);
            chk($sformatf("v%0d_valid_drop", i), int'(out_valid), 0);
            chk($sformatf("v%0d_ready_back", i), int'(in_ready), 1);
        end

        // Back-to-back words with in_valid held; second would hit if state leaked.
        in_valid = 1'b1;
        in_data  = 8'b00000101;
        t0 = cyc;
        @(negedge clk);
        in_data = 8'b10000000;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_w0_count", int'(out_count), 0);
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        chk("b2b_period", t1 - t0, 10);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("b2b_w1_valid", int'(out_valid), 1);
        chk("b2b_w1_count", int'(out_count), 0);
        chk("b2b_w1_first", int'(out_first), 8);
        @(negedge clk);

        // Result held while consumer stalls; input pulses must be ignored.
        out_ready = 1'b0;
        send_word(8'b10110110, lat, c, f);
        chk("stall_latency", lat, 8);
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            in_data  = 8'hFF;
            @(negedge clk);
            chk($sformatf("stall%0d_valid", k), int'(out_valid), 1);
            chk($sformatf("stall%0d_count", k), int'(out_count), 2);
            chk($sformatf("stall%0d_first", k), int'(out_first), 4);
            chk($sformatf("stall%0d_ready", k), int'(in_ready), 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stall_release_valid", int'(out_valid), 0);
        chk("stall_release_ready", int'(in_ready), 1);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("stall_no_ghost_word", seen, 0);

        // Reset on the third shift edge discards the word.
        in_valid = 1'b1;
        in_data  = 8'b10110110;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_in_ready",  int'(in_ready), 1);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_det_rst",   int'(det_rst), 1);
        chk("midrst_det_in",    int'(det_data_in), 0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("midrst_no_result", seen, 0);
        send_word(8'b10110110, lat, c, f);
        chk("midrst_resend_count", c, 2);
        chk("midrst_resend_first", f, 4);
        @(negedge clk);

        // Wide instance with saturating 2-bit counter.
        in_valid2 = 1'b1;
        in_data2  = 32'hB6DB6DB6;
        @(negedge clk);
        in_valid2 = 1'b0;
        lat = 0;
        while (!out_valid2 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        chk("w32_latency", lat, 32);
        chk("w32_count",   int'(out_count2), 3);
        chk("w32_first",   int'(out_first2), 4);
        @(negedge clk);
        chk("w32_ready_back", int'(in_ready2), 1);

        chk("ready_only_idle", viol, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
